// File: rtl/counters_pkg.sv
// counters_pkg: shared types and constants for the 9-bit counter blocks.
package counters_pkg;
  typedef logic [8:0] cnt9_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dc_state_t;
  localparam cnt9_t CNT9_ZERO = '0;
endpackage

// File: rtl/sub9_downcounter_sub9.sv
// sub9: combinational 9-bit subtractor, z = x - y, bout set on underflow.
module sub9
  import counters_pkg::*;
(
  input  cnt9_t x,
  input  cnt9_t y,
  output cnt9_t z,
  output logic  bout
);
  logic cout;
  // Adder with inverted y and carry-in 1; a missing carry-out means a borrow.
  assign {cout, z} = {1'b0, x} + {1'b0, ~y} + 10'd1;
  assign bout = ~cout;
endmodule

// File: rtl/sub9_downcounter.sv
// sub9_downcounter: loadable 9-bit down-counter stepping by STEP until exhausted.
module sub9_downcounter
  import counters_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] step,
  input  logic             start,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             borrow,
  output logic             tc,
  output logic             done
);
  logic [1:0] rst_sync;
  logic       rst_i_n;
  dc_state_t  state, state_d;
  cnt9_t      count_d, diff, res;
  logic       bout, borrow_d;
  // Reset asserts asynchronously but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];
  sub9 u_sub9 (.x(count), .y(step), .z(diff), .bout(bout));
  assign res = (bout && SATURATE) ? CNT9_ZERO : diff;
  always_comb begin
    state_d  = state;
    count_d  = count;
    borrow_d = 1'b0;
    if (load) begin
      count_d = count_in;
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: state_d = start ? RUN : IDLE;
        RUN:
          if (abort) state_d = IDLE;
          else if (enable) begin
            count_d  = res;
            borrow_d = bout;
            state_d  = (bout || res == CNT9_ZERO) ? DONE : RUN;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      state  <= IDLE;
      count  <= CNT9_ZERO;
      borrow <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      borrow <= borrow_d;
    end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign tc   = count == CNT9_ZERO;
endmodule

// File: tb/tb_sub9_downcounter.sv
// tb_sub9_downcounter: scoreboard bench with directed vectors for both SATURATE settings.
module tb_sub9_downcounter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, enable = 1'b0, abort = 1'b0;
  logic [8:0] count_in = '0, step = '0;
  logic [8:0] count, count_w;
  logic       busy, borrow, tc, done;
  logic       busy_w, borrow_w, tc_w, done_w;
  int         cyc = 0, compared = 0, mismatched = 0;
  typedef struct packed {
    int         cyc;
    logic [8:0] c;
    logic [8:0] cw;
    logic       busy;
    logic       borrow;
    logic       done;
  } exp_t;
  exp_t  exq[$];
  string nmq[$];
  exp_t  e;
  string n;
  sub9_downcounter #(.WIDTH(9), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .count_in(count_in), .step(step),
    .start(start), .enable(enable), .abort(abort), .count(count), .busy(busy),
    .borrow(borrow), .tc(tc), .done(done));
  sub9_downcounter #(.WIDTH(9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .load(load), .count_in(count_in), .step(step),
    .start(start), .enable(enable), .abort(abort), .count(count_w), .busy(busy_w),
    .borrow(borrow_w), .tc(tc_w), .done(done_w));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (exq.size() > 0 && exq[0].cyc <= cyc) begin
      e = exq.pop_front();
      n = nmq.pop_front();
      compared++;
      if (e.cyc != cyc || count !== e.c || count_w !== e.cw || busy !== e.busy ||
          borrow !== e.borrow || done !== e.done || tc !== (e.c == 9'd0)) begin
        mismatched++;
        $display("FAIL %s @cyc %0d (due %0d): got count=%h count_w=%h busy=%b borrow=%b done=%b tc=%b, want count=%h count_w=%h busy=%b borrow=%b done=%b tc=%b",
                 n, cyc, e.cyc, count, count_w, busy, borrow, done, tc,
                 e.c, e.cw, e.busy, e.borrow, e.done, e.c == 9'd0);
      end
    end
  function automatic void push(input string nm, input int at, input logic [8:0] c, cw,
                               input logic b, br, d);
    exq.push_back('{cyc: at, c: c, cw: cw, busy: b, borrow: br, done: d});
    nmq.push_back(nm);
  endfunction
  task automatic drive(input string nm, input logic ld, input logic [8:0] ci,
                       input logic st, en, ab, input logic [8:0] c, cw,
                       input logic b, br, d);
    push(nm, cyc + 1, c, cw, b, br, d);
    load = ld; count_in = ci; start = st; enable = en; abort = ab;
    @(negedge clk);
  endtask
  initial begin
    drive("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) drive("rst_sync", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Exact run: 0x010 by 4.
    step = 9'd4;
    drive("x_load",  1, 9'h010, 0, 0, 0, 9'h010, 9'h010, 0, 0, 0);
    drive("x_start", 0, 0,      1, 0, 0, 9'h010, 9'h010, 1, 0, 0);
    drive("x_d1",    0, 0,      0, 1, 0, 9'h00C, 9'h00C, 1, 0, 0);
    drive("x_d2",    0, 0,      0, 1, 0, 9'h008, 9'h008, 1, 0, 0);
    drive("x_d3",    0, 0,      0, 1, 0, 9'h004, 9'h004, 1, 0, 0);
    drive("x_d4",    0, 0,      0, 1, 0, 9'h000, 9'h000, 0, 0, 1);
    drive("x_idle",  0, 0,      0, 1, 0, 9'h000, 9'h000, 0, 0, 0);
    // Underflow: 5 by 3, saturating vs wrapping.
    step = 9'd3;
    drive("u_load",  1, 9'h005, 0, 0, 0, 9'h005, 9'h005, 0, 0, 0);
    drive("u_start", 0, 0,      1, 0, 0, 9'h005, 9'h005, 1, 0, 0);
    drive("u_d1",    0, 0,      0, 1, 0, 9'h002, 9'h002, 1, 0, 0);
    drive("u_d2",    0, 0,      0, 1, 0, 9'h000, 9'h1FF, 0, 1, 1);
    drive("u_idle",  0, 0,      0, 0, 0, 9'h000, 9'h1FF, 0, 0, 0);
    // Wide values: full 9-bit borrow chain.
    step = 9'h100;
    drive("w_load",  1, 9'h1FF, 0, 0, 0, 9'h1FF, 9'h1FF, 0, 0, 0);
    drive("w_start", 0, 0,      1, 0, 0, 9'h1FF, 9'h1FF, 1, 0, 0);
    drive("w_d1",    0, 0,      0, 1, 0, 9'h0FF, 9'h0FF, 1, 0, 0);
    drive("w_d2",    0, 0,      0, 1, 0, 9'h000, 9'h1FF, 0, 1, 1);
    drive("w_idle",  0, 0,      0, 0, 0, 9'h000, 9'h1FF, 0, 0, 0);
    // Enable gaps, then abort.
    step = 9'd1;
    drive("g_load",  1, 9'h020, 0, 0, 0, 9'h020, 9'h020, 0, 0, 0);
    drive("g_start", 0, 0,      1, 0, 0, 9'h020, 9'h020, 1, 0, 0);
    drive("g_en1",   0, 0,      0, 1, 0, 9'h01F, 9'h01F, 1, 0, 0);
    drive("g_en0",   0, 0,      0, 0, 0, 9'h01F, 9'h01F, 1, 0, 0);
    drive("g_en1b",  0, 0,      0, 1, 0, 9'h01E, 9'h01E, 1, 0, 0);
    drive("g_abort", 0, 0,      0, 1, 1, 9'h01E, 9'h01E, 0, 0, 0);
    drive("g_idle",  0, 0,      0, 0, 0, 9'h01E, 9'h01E, 0, 0, 0);
    // LOAD beats ABORT/ENABLE/START in RUN.
    step = 9'd2;
    drive("p_load",  1, 9'h030, 0, 0, 0, 9'h030, 9'h030, 0, 0, 0);
    drive("p_start", 0, 0,      1, 0, 0, 9'h030, 9'h030, 1, 0, 0);
    drive("p_d1",    0, 0,      0, 1, 0, 9'h02E, 9'h02E, 1, 0, 0);
    drive("p_ldab",  1, 9'h077, 1, 1, 1, 9'h077, 9'h077, 0, 0, 0);
    drive("p_idle",  0, 0,      0, 0, 0, 9'h077, 9'h077, 0, 0, 0);
    // STEP = 0 never terminates; only LOAD exits.
    step = 9'd0;
    drive("z_load",  1, 9'h040, 0, 0, 0, 9'h040, 9'h040, 0, 0, 0);
    drive("z_start", 0, 0,      1, 0, 0, 9'h040, 9'h040, 1, 0, 0);
    for (int i = 0; i < 50; i++) drive("z_hold", 0, 0, 0, 1, 0, 9'h040, 9'h040, 1, 0, 0);
    drive("z_exit",  1, 9'h0A5, 0, 1, 0, 9'h0A5, 9'h0A5, 0, 0, 0);
    drive("z_rerun", 0, 0,      1, 0, 0, 9'h0A5, 9'h0A5, 1, 0, 0);
    drive("z_run",   0, 0,      0, 1, 0, 9'h0A5, 9'h0A5, 1, 0, 0);
    // Asynchronous reset mid-run, checked before the next rising edge.
    @(posedge clk);
    #1 rst_n = 1'b0;
    push("r_async", cyc, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive("r_hold", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) drive("r_sync", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // START with COUNT = 0 completes on the first enabled cycle.
    step = 9'd5;
    drive("s_start", 0, 0, 1, 0, 0, 9'h000, 9'h000, 1, 0, 0);
    drive("s_d1",    0, 0, 0, 1, 0, 9'h000, 9'h1FB, 0, 1, 1);
    drive("s_idle",  0, 0, 0, 0, 0, 9'h000, 9'h1FB, 0, 0, 0);
    repeat (3) @(negedge clk);
    compared++;
    if (exq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
